tt_um_weight_loader: RTL and testbench
======================================

// Module: tt_um_weight_loader
// PURPOSE
//  Byte-stream writer for the ternary weight matrix consumed by tt_um_mult.
//  - Receives packed 2-bit ternary weights over an 8-bit valid/ready stream.
//  - Assembles them in a shadow buffer.
//  - Commits the whole matrix atomically to the W output, so the multiplier never sees a partial matrix.
// PARAMETERS
//  InLen    16  rows of W (input-vector length); InLen*OutLen must be a multiple of 4
//  OutLen   8   columns of W (output-vector length)
//  NBytes   InLen*OutLen/4 (localparam, 32 at defaults)  bytes per full matrix load
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        async active-low reset
//  load_start  in   1        begin a new load; aborts any load in progress
//  in_valid    in   1        in_data carries a byte
//  in_data     in   8        four packed weights, bits[1:0] first
//  in_ready    out  1        loader accepts a byte this cycle
//  W           out  2 x [InLen][OutLen]  signed ternary weights, unpacked array
//  w_valid     out  1        a complete matrix has been committed since reset
//  load_busy   out  1        FSM in LOAD or COMMIT
//  load_done   out  1        1-cycle pulse, the cycle after W updates
//  enc_err     out  1        sticky: illegal code 2'b10 seen in current/last load
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs are cleared immediately.
//   - W = all 2'b00; w_valid, load_busy, load_done, enc_err, in_ready = 0.
//   - FSM = IDLE, byte count = 0, shadow cleared.
//   - Reset mid-load also clears a previously committed W.
//  Encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
//   - 2'b10 is illegal: stored as 2'b00 and sets enc_err.
//  Ordering: byte k carries weight index 4k+j (j = 0..3) in in_data[2j+1:2j].
//   - Index idx maps to row = idx / OutLen, col = idx % OutLen (row-major).
//  FSM states: IDLE, LOAD, COMMIT.
//   - IDLE: in_ready = 0; bytes are ignored.
//     load_start -> LOAD; cnt = 0; enc_err cleared.
//   - LOAD: in_ready = 1. On in_valid && in_ready, write four shadow weights and do cnt++.
//     The transfer that accepts byte NBytes-1 goes -> COMMIT.
//   - COMMIT: in_ready = 0. W <= shadow (all entries in one edge); w_valid <= 1;
//     load_done <= 1 for one cycle. Then -> IDLE, or -> LOAD if load_start is high in COMMIT.
//  Latency: last byte accepted at edge N.
//   - W and w_valid change at edge N+1.
//   - load_done is high for the cycle after edge N+1.
//  Simultaneous events:
//   - load_start in LOAD takes priority over in_valid. That byte is dropped, cnt = 0,
//     shadow is discarded, enc_err is cleared, and W is left unchanged.
//   - load_start in COMMIT: the commit still completes; enc_err is cleared for the new load.
//   - in_valid while in_ready = 0: ignored, with no side effects.
//  W holds its value between commits. The multiplier may run freely during a load.
//  load_busy = (state != IDLE).
// TESTING
//  1. Reset, then load_start and 32 bytes of 8'h55 -> at edge N+1 all W = +1,
//     w_valid = 1, one load_done pulse, enc_err = 0.
//  2. Load 32 bytes of 8'hFF, then load 32 bytes of 8'h00 -> W goes to all -1, then to all 0.
//     W stays all -1 until the second commit edge.
//  3. Byte 0 = 8'h1D (codes 01,11,01,00) -> W[0][0] = +1, W[0][1] = -1, W[0][2] = +1, W[0][3] = 0.
//     Byte 2 = 8'h01 -> W[1][0] = +1.
//  4. Byte 5 = 8'h02 (code 10) -> W[2][4] = 0, enc_err = 1 after commit.
//     enc_err clears on the next load_start.
//  5. After 10 bytes, assert load_start with in_valid high -> that byte is dropped and W is unchanged.
//     32 further bytes are needed before the next load_done.
//  6. Drop rst_n mid-load after a prior commit -> W = 0 and w_valid = 0 immediately.
//     in_ready stays 0 until the next load_start.

Source files
------------

// File: rtl/tt_um_weight_loader.sv
// Ternary weight loader: accepts packed 2-bit weights over a byte stream into a shadow buffer,
// then commits the full matrix to W in a single edge.
module tt_um_weight_loader #(
  parameter int unsigned InLen  = 16,
  parameter int unsigned OutLen = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic signed [1:0] W [InLen][OutLen],
  output logic              w_valid,
  output logic              load_busy,
  output logic              load_done,
  output logic              enc_err
);

  localparam int unsigned NW     = InLen * OutLen;
  localparam int unsigned NBytes = NW / 4;
  localparam int unsigned CntW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [1:0]         shadow_q [NW];
  logic [1:0]         shadow_d [NW];
  logic signed [1:0]  w_q [InLen][OutLen];
  logic               w_valid_q, load_done_q, enc_err_q, enc_err_d;
  logic [1:0]         code [4];
  logic               byte_err;

  // Illegal code 2'b10 is stored as zero and flagged.
  always_comb begin
    byte_err = 1'b0;
    for (int j = 0; j < 4; j++) begin
      code[j] = in_data[2*j +: 2];
      if (code[j] == 2'b10) begin
        code[j]  = 2'b00;
        byte_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enc_err_d = enc_err_q;
    shadow_d  = shadow_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) state_d = StLoad;
      end
      StLoad: begin
        if (!load_start && in_valid) begin
          for (int i = 0; i < int'(NW); i++) begin
            if ((i / 4) == int'(cnt_q)) shadow_d[i] = code[i % 4];
          end
          cnt_d = cnt_q + CntW'(1);
          if (byte_err) enc_err_d = 1'b1;
          if (cnt_q == CntW'(NBytes - 1)) state_d = StCommit;
        end
      end
      StCommit: begin
        state_d = load_start ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new load always starts from a clean slate, whatever state it arrives in.
    if (load_start) begin
      cnt_d     = '0;
      enc_err_d = 1'b0;
      for (int i = 0; i < int'(NW); i++) shadow_d[i] = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      enc_err_q   <= 1'b0;
      w_valid_q   <= 1'b0;
      load_done_q <= 1'b0;
      for (int i = 0; i < int'(NW); i++) shadow_q[i] <= 2'b00;
      for (int r = 0; r < int'(InLen); r++) begin
        for (int c = 0; c < int'(OutLen); c++) w_q[r][c] <= 2'sb00;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enc_err_q   <= enc_err_d;
      shadow_q    <= shadow_d;
      load_done_q <= (state_q == StCommit);
      if (state_q == StCommit) begin
        w_valid_q <= 1'b1;
        for (int r = 0; r < int'(InLen); r++) begin
          for (int c = 0; c < int'(OutLen); c++) w_q[r][c] <= shadow_q[r*OutLen + c];
        end
      end
    end
  end

  assign W         = w_q;
  assign in_ready  = (state_q == StLoad);
  assign load_busy = (state_q != StIdle);
  assign w_valid   = w_valid_q;
  assign load_done = load_done_q;
  assign enc_err   = enc_err_q;

endmodule

// File: tb/tb_tt_um_weight_loader.sv
// Directed bench for tt_um_weight_loader: table of full-matrix loads with per-element
// expectations, plus hand sequences for abort, restart-in-commit and mid-load reset.
module tb_tt_um_weight_loader;

  logic              clk, rst_n, load_start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, w_valid, load_busy, load_done, enc_err;
  logic signed [1:0] w_out [16][8];

  tt_um_weight_loader #(.InLen(16), .OutLen(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .W          (w_out),
    .w_valid    (w_valid),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .enc_err    (enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        fill;
    int                pk_idx;
    logic [7:0]        pk_val;
    int                r;
    int                c;
    logic signed [1:0] exp_w;
    logic              exp_err;
  } vec_t;

  vec_t              vecs [15];
  logic [7:0]        img [32];
  logic signed [1:0] cur_w  [16][8];
  logic signed [1:0] prev_w [16][8];
  int                n_vec = 0;
  int                n_err = 0;

  function automatic void chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Reference decode of img into the expected matrix.
  function automatic void build_exp();
    logic [7:0] b;
    logic [1:0] cd;
    for (int idx = 0; idx < 128; idx++) begin
      b  = img[idx / 4];
      cd = b[2*(idx % 4) +: 2];
      cur_w[idx / 8][idx % 8] = (cd == 2'b10) ? 2'sb00 : $signed(cd);
    end
  endfunction

  function automatic int w_matches(input bit use_prev);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (w_out[r][c] != (use_prev ? prev_w[r][c] : cur_w[r][c])) return 0;
      end
    end
    return 1;
  endfunction

  function automatic void fill_img(input logic [7:0] v);
    for (int k = 0; k < 32; k++) img[k] = v;
  endfunction

  // Called at a negedge; leaves the bench at a negedge.
  task automatic run_load(input bit do_start, input bit restart, input logic exp_err);
    build_exp();
    if (do_start) begin
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
    end
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_data  = img[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    // Commit cycle: W must still hold the previous matrix.
    chk("commit_busy", int'(load_busy), 1);
    chk("commit_ready", int'(in_ready), 0);
    chk("commit_done_early", int'(load_done), 0);
    chk("commit_w_hold", w_matches(1'b1), 1);
    chk("commit_enc_err", int'(enc_err), int'(exp_err));
    load_start = restart;
    @(negedge clk);
    load_start = 1'b0;
    chk("done_pulse", int'(load_done), 1);
    chk("w_valid", int'(w_valid), 1);
    chk("w_full", w_matches(1'b0), 1);
    chk("enc_err", int'(enc_err), restart ? 0 : int'(exp_err));
    chk("busy_after", int'(load_busy), int'(restart));
    prev_w = cur_w;
    if (!restart) begin
      @(negedge clk);
      chk("done_clear", int'(load_done), 0);
      chk("idle_busy", int'(load_busy), 0);
    end
  endtask

  initial begin
    vecs[0]  = '{8'h55, 0,  8'h55, 0,  0,  2'sb01, 1'b0};
    vecs[1]  = '{8'h55, 0,  8'h55, 15, 7,  2'sb01, 1'b0};
    vecs[2]  = '{8'hFF, 0,  8'hFF, 3,  5,  2'sb11, 1'b0};
    vecs[3]  = '{8'h00, 0,  8'h00, 7,  2,  2'sb00, 1'b0};
    vecs[4]  = '{8'h00, 0,  8'h1D, 0,  0,  2'sb01, 1'b0};
    vecs[5]  = '{8'h00, 0,  8'h1D, 0,  1,  2'sb11, 1'b0};
    vecs[6]  = '{8'h00, 0,  8'h1D, 0,  2,  2'sb01, 1'b0};
    vecs[7]  = '{8'h00, 0,  8'h1D, 0,  3,  2'sb00, 1'b0};
    vecs[8]  = '{8'h00, 2,  8'h01, 1,  0,  2'sb01, 1'b0};
    vecs[9]  = '{8'h00, 5,  8'h02, 2,  4,  2'sb00, 1'b1};
    vecs[10] = '{8'h55, 5,  8'h56, 2,  4,  2'sb00, 1'b1};
    vecs[11] = '{8'h55, 5,  8'h56, 2,  5,  2'sb01, 1'b1};
    vecs[12] = '{8'hAA, 0,  8'hAA, 9,  3,  2'sb00, 1'b1};
    vecs[13] = '{8'h55, 31, 8'hC0, 15, 7,  2'sb11, 1'b0};
    vecs[14] = '{8'h55, 31, 8'hC0, 15, 4,  2'sb00, 1'b0};

    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) prev_w[r][c] = 2'sb00;
    end
    rst_n = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_w_valid", int'(w_valid), 0);
    chk("rst_busy", int'(load_busy), 0);
    chk("rst_done", int'(load_done), 0);
    chk("rst_enc_err", int'(enc_err), 0);
    chk("rst_w_zero", w_matches(1'b1), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Bytes offered in IDLE are ignored.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (2) @(negedge clk);
    chk("idle_ready", int'(in_ready), 0);
    chk("idle_busy0", int'(load_busy), 0);
    chk("idle_w_zero", w_matches(1'b1), 1);
    in_valid = 1'b0;

    for (int v = 0; v < 15; v++) begin
      fill_img(vecs[v].fill);
      img[vecs[v].pk_idx] = vecs[v].pk_val;
      run_load(1'b1, 1'b0, vecs[v].exp_err);
      chk($sformatf("vec%0d_w[%0d][%0d]", v, vecs[v].r, vecs[v].c),
          int'(w_out[vecs[v].r][vecs[v].c]), int'(vecs[v].exp_w));
    end

    // Abort after 10 bytes with in_valid high: byte dropped, count and enc_err restart.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 8'hAA;
      @(negedge clk);
    end
    chk("abort_pre_err", int'(enc_err), 1);
    load_start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    load_start = 1'b0; in_valid = 1'b0;
    chk("abort_err_clr", int'(enc_err), 0);
    chk("abort_ready", int'(in_ready), 1);
    chk("abort_w_hold", w_matches(1'b1), 1);
    fill_img(8'h55);
    run_load(1'b0, 1'b0, 1'b0);

    // load_start during COMMIT: commit completes, new load begins with enc_err cleared.
    fill_img(8'hAA);
    run_load(1'b1, 1'b1, 1'b1);
    chk("restart_ready", int'(in_ready), 1);
    fill_img(8'hFF);
    img[7] = 8'h0D;
    run_load(1'b0, 1'b0, 1'b0);
    chk("restart_w[3][4]", int'(w_out[3][4]), 1);
    chk("restart_w[3][5]", int'(w_out[3][5]), -1);

    // Reset mid-load clears the committed matrix immediately.
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w00", int'(w_out[0][0]), 0);
    chk("mid_rst_w157", int'(w_out[15][7]), 0);
    chk("mid_rst_w_valid", int'(w_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_busy", int'(load_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", int'(in_ready), 0);
    chk("post_rst_w_valid", int'(w_valid), 0);
    in_valid = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("post_rst_start", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
